// File: rtl/bcd_clock_gen_pkg.sv
// rtl/bcd_clock_gen_pkg.sv - shared BCD time types and helpers for bcd_clock_gen
// Contents:
//   bcd_digit_t  one BCD digit
//   dow_t        day of week 0..6
//   frac_bcd_t   up to six fractional BCD digits, index 0 = least significant
//   time_t       hh:mm:ss plus the three most significant fractional digits
//   bcd_to_12h   24h BCD hour -> 12h BCD hour
//   dec_digit    decimal digit at a given position of a constant
package bcd_clock_gen_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [2:0] dow_t;

  localparam int unsigned MAX_FRAC_DIGITS = 6;
  typedef bcd_digit_t frac_bcd_t [MAX_FRAC_DIGITS];

  typedef struct packed {
    bcd_digit_t hour_10;
    bcd_digit_t hour_1;
    bcd_digit_t min_10;
    bcd_digit_t min_1;
    bcd_digit_t sec_10;
    bcd_digit_t sec_1;
    bcd_digit_t t_100ms;
    bcd_digit_t t_10ms;
    bcd_digit_t t_1ms;
  } time_t;

  localparam bcd_digit_t MOD_DEC  = 4'd10;
  localparam bcd_digit_t MOD_SIX  = 4'd6;
  localparam bcd_digit_t MOD_HR10 = 4'd3;

  // Hours outside 00..23 (only reachable through an illegal load) pass through.
  function automatic logic [7:0] bcd_to_12h(input bcd_digit_t h10, input bcd_digit_t h1);
    logic [7:0] hr;
    logic [7:0] r;
    hr = {4'd0, h10} * 8'd10 + {4'd0, h1};
    if (hr == 8'd0)                        r = 8'h12;
    else if (hr >= 8'd13 && hr <= 8'd21)   r = {4'd0, 4'(hr - 8'd12)};
    else if (hr == 8'd22)                  r = 8'h10;
    else if (hr == 8'd23)                  r = 8'h11;
    else                                   r = {h10, h1};
    return r;
  endfunction

  function automatic bcd_digit_t dec_digit(input int unsigned v, input int pos);
    int unsigned p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    return bcd_digit_t'((v / p) % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - one BCD digit counter with load and registered terminal count
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         advance by one (wraps at modulus-1 -> 0)
//   modulus    digit modulus (10 for a decimal digit, 6 for tens of seconds, ...)
//   load       load load_val this edge; wins over en
//   load_val   value to load (may be out of range; recovers at next wrap)
//   cnt_q      current digit
//   tc_q       registered: cnt_q is at or beyond its last legal value
module bcd_digit_cnt
  import bcd_clock_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  bcd_digit_t modulus,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t cnt_q,
  output logic       tc_q
);

  bcd_digit_t cnt_d;
  bcd_digit_t last;
  logic       tc_d;

  // ">=" rather than "==" so an out-of-range loaded value wraps to 0 and
  // carries on its next advance instead of counting up to 15.
  always_comb begin
    last  = modulus - 4'd1;
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = (cnt_q >= last) ? 4'd0 : cnt_q + 4'd1;
    tc_d = (cnt_d >= last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

endmodule

// File: rtl/bcd_clock_gen.sv
// rtl/bcd_clock_gen.sv - parametrised BCD time-of-day clock with PPS-aligned set
// Optional feature macro: BCD_CLOCK_LEAP_SEC_EN (adds leap_ins / leap_del)
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tsc_1pps      one-cycle pulse per second boundary
//   tsc_tick      one-cycle pulse per fractional LSB
//   set           request load of set_time/set_dow at the next PPS
//   set_time      hh:mm:ss to load (fractional fields ignored)
//   set_dow       day of week to load
//   mode_12h      12h presentation of the cur_time hour digits
//   leap_ins/del  (macro only) arm leap second insert / delete
//   cur_time      current time, three MS fractional digits
//   frac_bcd      all fractional digits, MS digit in top nibble
//   pm            internal hour in 12..23
//   dow           day of week
//   day_tick      one-cycle pulse with the wrap to 00:00:00
//   sync_pending  set request waiting for PPS
module bcd_clock_gen
  import bcd_clock_gen_pkg::*;
#(
  parameter int unsigned FRAC_DIGITS = 3,
  parameter int unsigned PRELOAD     = 2,
  parameter int unsigned DOW_RESET   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tsc_1pps,
  input  logic                     tsc_tick,
  input  logic                     set,
  input  time_t                    set_time,
  input  dow_t                     set_dow,
  input  logic                     mode_12h,
`ifdef BCD_CLOCK_LEAP_SEC_EN
  input  logic                     leap_ins,
  input  logic                     leap_del,
`endif
  output time_t                    cur_time,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd,
  output logic                     pm,
  output dow_t                     dow,
  output logic                     day_tick,
  output logic                     sync_pending
);

  logic sync_pending_q, sync_pending_d;
  dow_t dow_q, dow_d;
  logic day_tick_q, day_tick_d;

  logic do_load, tick_eff;
  logic [FRAC_DIGITS-1:0] frac_en, frac_tc;
  bcd_digit_t frac_cnt [FRAC_DIGITS];
  logic frac_run, frac_wrap;

  bcd_digit_t s1_cnt, s10_cnt, m1_cnt, m10_cnt, h1_cnt, h10_cnt;
  logic s1_tc, s10_tc, m1_tc, m10_tc, h1_tc, h10_tc_unused;
  logic sec_is_59, min_is_59, hr_is_23, sec_is_60;
  logic ins_apply, del_apply;
  logic sec_wrap, sec_load, min_wrap, midnight, hr_load;
  bcd_digit_t s1_load_val, s10_load_val, h1_load_val, h10_load_val;
  logic [7:0] hour_disp;
  logic unused_set_frac;

  assign unused_set_frac = ^{set_time.t_100ms, set_time.t_10ms, set_time.t_1ms};

  // A set coincident with PPS while idle only arms; the load needs an
  // already-pending request at the PPS.
  assign do_load  = tsc_1pps & sync_pending_q;
  assign tick_eff = tsc_tick & ~do_load;

  // Each digit advances when every lower digit already sits at its terminal
  // value; those flags are registered, so the ripple costs no latency.
  always_comb begin
    frac_en  = '0;
    frac_run = tick_eff;
    for (int i = 0; i < FRAC_DIGITS; i++) begin
      frac_en[i] = frac_run;
      frac_run   = frac_run & frac_tc[i];
    end
    frac_wrap = frac_run;
  end

  for (genvar g = 0; g < FRAC_DIGITS; g++) begin : g_frac
    localparam bcd_digit_t PRE_DIGIT = dec_digit(PRELOAD, g);
    bcd_digit_cnt u_digit (
      .clk(clk), .rst(rst), .en(frac_en[g]), .modulus(MOD_DEC),
      .load(do_load), .load_val(PRE_DIGIT),
      .cnt_q(frac_cnt[g]), .tc_q(frac_tc[g])
    );
    assign frac_bcd[4*g +: 4] = frac_cnt[g];
  end

  assign sec_is_59 = s1_tc & s10_tc;
  assign min_is_59 = m1_tc & m10_tc;
  assign hr_is_23  = (h10_cnt == 4'd2) && (h1_cnt == 4'd3);

`ifdef BCD_CLOCK_LEAP_SEC_EN
  logic leap_ins_q, leap_ins_d, leap_del_q, leap_del_d;
  logic sec_is_58;

  assign sec_is_60 = (s10_cnt == 4'd6) && (s1_cnt == 4'd0);
  assign sec_is_58 = (s10_cnt == 4'd5) && (s1_cnt == 4'd8);
  assign ins_apply = frac_wrap & leap_ins_q & sec_is_59 & min_is_59 & hr_is_23;
  assign del_apply = frac_wrap & leap_del_q & sec_is_58 & min_is_59 & hr_is_23;

  // Contradictory requests cancel each other out.
  always_comb begin
    leap_ins_d = leap_ins_q | leap_ins;
    leap_del_d = leap_del_q | leap_del;
    if (leap_ins_d && leap_del_d) begin
      leap_ins_d = 1'b0;
      leap_del_d = 1'b0;
    end
    if (do_load || ins_apply) leap_ins_d = 1'b0;
    if (do_load || del_apply) leap_del_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leap_ins_q <= 1'b0;
      leap_del_q <= 1'b0;
    end else begin
      leap_ins_q <= leap_ins_d;
      leap_del_q <= leap_del_d;
    end
  end
`else
  assign sec_is_60 = 1'b0;
  assign ins_apply = 1'b0;
  assign del_apply = 1'b0;
`endif

  // Leap insert parks seconds at 60 without carrying; second 60 (and a leap
  // delete at :58) force seconds to 00 and carry into the minutes.
  always_comb begin
    sec_wrap     = frac_wrap & ((sec_is_59 & ~ins_apply) | sec_is_60 | del_apply);
    sec_load     = do_load | ins_apply | (frac_wrap & (sec_is_60 | del_apply));
    s1_load_val  = do_load ? set_time.sec_1 : 4'd0;
    s10_load_val = do_load ? set_time.sec_10 : (ins_apply ? 4'd6 : 4'd0);
    min_wrap     = sec_wrap & min_is_59;
    midnight     = min_wrap & hr_is_23;
    hr_load      = do_load | midnight;
    h1_load_val  = do_load ? set_time.hour_1 : 4'd0;
    h10_load_val = do_load ? set_time.hour_10 : 4'd0;
  end

  bcd_digit_cnt u_s1 (
    .clk(clk), .rst(rst), .en(frac_wrap), .modulus(MOD_DEC),
    .load(sec_load), .load_val(s1_load_val), .cnt_q(s1_cnt), .tc_q(s1_tc)
  );
  bcd_digit_cnt u_s10 (
    .clk(clk), .rst(rst), .en(frac_wrap & s1_tc), .modulus(MOD_SIX),
    .load(sec_load), .load_val(s10_load_val), .cnt_q(s10_cnt), .tc_q(s10_tc)
  );
  bcd_digit_cnt u_m1 (
    .clk(clk), .rst(rst), .en(sec_wrap), .modulus(MOD_DEC),
    .load(do_load), .load_val(set_time.min_1), .cnt_q(m1_cnt), .tc_q(m1_tc)
  );
  bcd_digit_cnt u_m10 (
    .clk(clk), .rst(rst), .en(sec_wrap & m1_tc), .modulus(MOD_SIX),
    .load(do_load), .load_val(set_time.min_10), .cnt_q(m10_cnt), .tc_q(m10_tc)
  );
  // Hours count as a plain decimal pair; 23 -> 00 is forced through load.
  bcd_digit_cnt u_h1 (
    .clk(clk), .rst(rst), .en(min_wrap), .modulus(MOD_DEC),
    .load(hr_load), .load_val(h1_load_val), .cnt_q(h1_cnt), .tc_q(h1_tc)
  );
  bcd_digit_cnt u_h10 (
    .clk(clk), .rst(rst), .en(min_wrap & h1_tc), .modulus(MOD_HR10),
    .load(hr_load), .load_val(h10_load_val), .cnt_q(h10_cnt), .tc_q(h10_tc_unused)
  );

  always_comb begin
    sync_pending_d = set | (sync_pending_q & ~tsc_1pps);
    dow_d          = dow_q;
    if (do_load)       dow_d = set_dow;
    else if (midnight) dow_d = (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;
    day_tick_d     = midnight;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pending_q <= 1'b0;
      dow_q          <= dow_t'(DOW_RESET);
      day_tick_q     <= 1'b0;
    end else begin
      sync_pending_q <= sync_pending_d;
      dow_q          <= dow_d;
      day_tick_q     <= day_tick_d;
    end
  end

  always_comb begin
    hour_disp = mode_12h ? bcd_to_12h(h10_cnt, h1_cnt) : {h10_cnt, h1_cnt};
    cur_time  = {hour_disp, m10_cnt, m1_cnt, s10_cnt, s1_cnt,
                 frac_cnt[FRAC_DIGITS-1], frac_cnt[FRAC_DIGITS-2], frac_cnt[FRAC_DIGITS-3]};
    pm        = ((h10_cnt == 4'd1) && (h1_cnt >= 4'd2)) ||
                ((h10_cnt == 4'd2) && (h1_cnt <= 4'd3));
  end

  assign dow          = dow_q;
  assign day_tick     = day_tick_q;
  assign sync_pending = sync_pending_q;

endmodule

// File: tb/tb_bcd_clock_gen.sv
// tb/tb_bcd_clock_gen.sv - self-checking bench for bcd_clock_gen
module tb_bcd_clock_gen;
  import bcd_clock_gen_pkg::*;

  localparam int PRELOAD = 2;

  logic        clk = 1'b0;
  logic        rst, tsc_1pps, tsc_tick, set, mode_12h;
  time_t       set_time, cur_time;
  dow_t        set_dow, dow;
  logic [11:0] frac_bcd;
  logic        pm, day_tick, sync_pending;
`ifdef BCD_CLOCK_LEAP_SEC_EN
  logic        leap_ins, leap_del;
`endif

  int checks = 0;
  int errors = 0;

  int m_frac, m_sod, m_dow;
  bit m_pend, m_dt;

  typedef struct {
    int         hh;
    bit         mode;
    logic [7:0] exp_hr;
    bit         exp_pm;
  } vec_t;
  vec_t vecs [6];

  bcd_clock_gen #(.FRAC_DIGITS(3), .PRELOAD(PRELOAD), .DOW_RESET(0)) dut (
    .clk(clk), .rst(rst), .tsc_1pps(tsc_1pps), .tsc_tick(tsc_tick), .set(set),
    .set_time(set_time), .set_dow(set_dow), .mode_12h(mode_12h),
`ifdef BCD_CLOCK_LEAP_SEC_EN
    .leap_ins(leap_ins), .leap_del(leap_del),
`endif
    .cur_time(cur_time), .frac_bcd(frac_bcd), .pm(pm), .dow(dow),
    .day_tick(day_tick), .sync_pending(sync_pending)
  );

  always #5 clk = ~clk;

  function automatic time_t mk_time(input int hh, input int mm, input int ss, input int f);
    time_t t;
    t = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
         4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_frac = 0; m_sod = 0; m_dow = 0; m_pend = 0; m_dt = 0;
  endtask

  // Reference: time as seconds-of-day plus an integer fraction.
  task automatic m_step(input bit tick, input bit pps, input bit st, input time_t t, input int d);
    bit ld;
    ld = pps && m_pend;
    m_pend = st ? 1'b1 : (pps ? 1'b0 : m_pend);
    m_dt = 0;
    if (ld) begin
      m_sod = ((int'(t.hour_10) * 10 + int'(t.hour_1)) * 60 +
               int'(t.min_10) * 10 + int'(t.min_1)) * 60 + int'(t.sec_10) * 10 + int'(t.sec_1);
      m_dow = d;
      m_frac = PRELOAD;
    end else if (tick) begin
      m_frac++;
      if (m_frac == 1000) begin
        m_frac = 0;
        m_sod++;
        if (m_sod == 86400) begin
          m_sod = 0;
          m_dow = (m_dow + 1) % 7;
          m_dt = 1;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    int h, m, s, dh;
    time_t et;
    h = m_sod / 3600; m = (m_sod / 60) % 60; s = m_sod % 60;
    dh = h;
    if (mode_12h) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    et = mk_time(dh, m, s, m_frac);
    check(name, {cur_time, frac_bcd, pm, dow, day_tick, sync_pending},
          {et, et.t_100ms, et.t_10ms, et.t_1ms, (h >= 12), 3'(m_dow), m_dt, m_pend});
  endtask

  task automatic cycle(input bit tick, input bit pps, input bit st, input time_t t, input int d);
    tsc_tick = tick; tsc_1pps = pps; set = st; set_time = t; set_dow = 3'(d);
    m_step(tick, pps, st, t, d);
    @(posedge clk);
    @(negedge clk);
    tsc_tick = 0; tsc_1pps = 0; set = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cycle(1, 0, 0, mk_time(0, 0, 0, 0), 0);
  endtask

  task automatic load_time(input int hh, input int mm, input int ss, input int d);
    cycle(0, 0, 1, mk_time(hh, mm, ss, 0), d);
    cycle(0, 1, 0, mk_time(hh, mm, ss, 0), d);
  endtask

  initial begin
    time_t t;
    rst = 1; tsc_1pps = 0; tsc_tick = 0; set = 0; mode_12h = 0;
    set_time = '0; set_dow = '0;
`ifdef BCD_CLOCK_LEAP_SEC_EN
    leap_ins = 0; leap_del = 0;
`endif
    m_reset();
    vecs[0] = '{0,  1'b1, 8'h12, 1'b0};
    vecs[1] = '{12, 1'b1, 8'h12, 1'b1};
    vecs[2] = '{13, 1'b1, 8'h01, 1'b1};
    vecs[3] = '{23, 1'b1, 8'h11, 1'b1};
    vecs[4] = '{13, 1'b0, 8'h13, 1'b1};
    vecs[5] = '{9,  1'b0, 8'h09, 1'b0};
    @(negedge clk); @(negedge clk);
    rst = 0;

    // reset state
    check("reset_time", cur_time, '0);
    check("reset_frac", frac_bcd, 12'h000);
    check("reset_flags", {pm, dow, day_tick, sync_pending}, 6'd0);
    mode_12h = 1; #1;
    check("reset_12h", {cur_time.hour_10, cur_time.hour_1}, 8'h12);
    mode_12h = 0; #1;

    // fractional wrap carries into seconds on the same edge
    ticks(999);
    check("frac_999", {cur_time, frac_bcd}, {mk_time(0, 0, 0, 999), 12'h999});
    ticks(1);
    check("frac_wrap", {cur_time, frac_bcd}, {mk_time(0, 0, 1, 0), 12'h000});

    // PPS-aligned load
    cycle(0, 0, 1, mk_time(12, 34, 56, 0), 3);
    check("set_pending", {sync_pending, cur_time}, {1'b1, mk_time(0, 0, 1, 0)});
    cycle(0, 1, 0, mk_time(12, 34, 56, 0), 3);
    check("load_time", {sync_pending, dow, cur_time}, {1'b0, 3'd3, mk_time(12, 34, 56, 2)});

    // midnight
    load_time(23, 59, 59, 6);
    ticks(997);
    check("pre_midnight", {day_tick, dow, cur_time}, {1'b0, 3'd6, mk_time(23, 59, 59, 999)});
    ticks(1);
    check("midnight", {day_tick, dow, cur_time}, {1'b1, 3'd0, mk_time(0, 0, 0, 0)});
    cycle(0, 0, 0, mk_time(0, 0, 0, 0), 0);
    check("day_tick_one", {day_tick, dow}, {1'b0, 3'd0});

    // 12h presentation table
    for (int i = 0; i < 6; i++) begin
      load_time(vecs[i].hh, 0, 0, 0);
      mode_12h = vecs[i].mode; #1;
      check($sformatf("hour12_%0d", i), {cur_time.hour_10, cur_time.hour_1, pm},
            {vecs[i].exp_hr, vecs[i].exp_pm});
      mode_12h = 0; #1;
    end

    // set and PPS together while idle: arm only
    cycle(0, 1, 1, mk_time(1, 2, 3, 0), 2);
    check("set_pps_same", {sync_pending, cur_time}, {1'b1, mk_time(9, 0, 0, 2)});
    cycle(0, 1, 0, mk_time(1, 2, 3, 0), 2);
    check("set_pps_next", {sync_pending, dow, cur_time}, {1'b0, 3'd2, mk_time(1, 2, 3, 2)});

    // lone PPS ignored
    cycle(0, 1, 0, mk_time(7, 7, 7, 0), 5);
    check("pps_ignored", {dow, cur_time}, {3'd2, mk_time(1, 2, 3, 2)});

    // load beats a coincident tick
    cycle(0, 0, 1, mk_time(4, 5, 6, 0), 1);
    cycle(1, 1, 0, mk_time(4, 5, 6, 0), 1);
    check("load_over_tick", {cur_time, frac_bcd}, {mk_time(4, 5, 6, 2), 12'h002});

    // illegal seconds digit recovers at its next wrap
    t = mk_time(0, 0, 0, 0);
    t.sec_1 = 4'hC;
    cycle(0, 0, 1, t, 0);
    cycle(0, 1, 0, t, 0);
    t.t_1ms = 4'd2;
    check("illegal_loaded", cur_time, t);
    ticks(998);
    check("illegal_recover", cur_time, mk_time(0, 0, 10, 0));

`ifdef BCD_CLOCK_LEAP_SEC_EN
    load_time(23, 59, 59, 2);
    leap_ins = 1;
    cycle(0, 0, 0, mk_time(0, 0, 0, 0), 0);
    leap_ins = 0;
    ticks(998);
    check("leap_ins_60", {day_tick, dow, cur_time}, {1'b0, 3'd2, mk_time(23, 59, 60, 0)});
    ticks(1000);
    check("leap_ins_wrap", {day_tick, dow, cur_time}, {1'b1, 3'd3, mk_time(0, 0, 0, 0)});
    load_time(23, 59, 58, 4);
    leap_del = 1;
    cycle(0, 0, 0, mk_time(0, 0, 0, 0), 0);
    leap_del = 0;
    ticks(998);
    check("leap_del_wrap", {day_tick, dow, cur_time}, {1'b1, 3'd5, mk_time(0, 0, 0, 0)});
`endif

    // asynchronous reset mid-operation
    cycle(0, 0, 1, mk_time(5, 5, 5, 0), 4);
    rst = 1; #1;
    check("async_reset", {sync_pending, dow, cur_time, frac_bcd}, '0);
    @(negedge clk);
    rst = 0;
    m_reset();

    // randomized run against the reference model
    for (int i = 0; i < 12000; i++) begin
      int hh, mm, ss;
      check_model("random");
      hh = ($urandom_range(3) == 0) ? 23 : int'($urandom_range(23));
      mm = ($urandom_range(2) == 0) ? 59 : int'($urandom_range(59));
      ss = ($urandom_range(1) == 0) ? 59 : int'($urandom_range(59));
      mode_12h = $urandom_range(1);
      cycle($urandom_range(9) != 0, $urandom_range(399) == 0, $urandom_range(249) == 0,
            mk_time(hh, mm, ss, 0), int'($urandom_range(6)));
    end
    check_model("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
